divfreq_bank: RTL

DIVFREQ_BANK -- requirements
Module: divfreq_bank

---
 rtl/divfreq_pkg.sv | 21 ++
 rtl/divfreq_ch.sv | 85 ++++++++
 rtl/divfreq_bank.sv | 45 ++++
 3 files changed

// File: rtl/divfreq_pkg.sv
// Shared constants for the divided-clock bank: counter width and
// half-period counts for common output rates from a 50 MHz system clock.
package divfreq_pkg;

    localparam int CNT_W_DEFAULT = 25;

    localparam int HALF_1HZ   = 25000000;
    localparam int HALF_3HZ   = 8333333;
    localparam int HALF_5HZ   = 5000000;
    localparam int HALF_7HZ   = 3571429;
    localparam int HALF_10HZ  = 2500000;
    localparam int HALF_1KHZ  = 25000;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_WRAP  = 2'd2,
        ACT_SYNC  = 2'd3
    } ch_act_e;

endpackage

// File: rtl/divfreq_ch.sv
// One divider channel: counts half-periods, toggles its output at each
// boundary and strobes tick on the rising output edge.
module divfreq_ch
    import divfreq_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = HALF_1HZ
)(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             we,
    input  logic [CNT_W-1:0] half_in,
    input  logic             en,
    input  logic             sync,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_HALF =
        (DEFAULT_HALF < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] pend_reg;
    logic             div_reg;
    logic             tick_reg;
    logic [CNT_W-1:0] wr_half;
    ch_act_e          act_next;

    assign wr_half = (half_in == '0) ? CNT_W'(1) : half_in;

    // A write to a stopped channel may leave the frozen count above the new
    // half-period, so the boundary is taken at or beyond H-1.
    always_comb begin
        act_next = ACT_COUNT;
        if (sync)
            act_next = ACT_SYNC;
        else if (!en)
            act_next = ACT_HOLD;
        else if (cnt_reg >= half_reg - CNT_W'(1))
            act_next = ACT_WRAP;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg  <= '0;
            half_reg <= RST_HALF;
            pend_reg <= RST_HALF;
            div_reg  <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (we)
                pend_reg <= wr_half;
            case (act_next)
                ACT_SYNC: begin
                    cnt_reg  <= '0;
                    div_reg  <= 1'b0;
                    half_reg <= we ? wr_half : pend_reg;
                end
                ACT_HOLD: begin
                    if (we)
                        half_reg <= wr_half;
                end
                ACT_WRAP: begin
                    // The pending value is taken before any same-cycle write lands.
                    cnt_reg  <= '0;
                    div_reg  <= ~div_reg;
                    tick_reg <= ~div_reg;
                    half_reg <= pend_reg;
                end
                ACT_COUNT: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                default: begin
                    cnt_reg <= cnt_reg;
                end
            endcase
        end
    end

    assign clk_div = div_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/divfreq_bank.sv
// Bank of independent clock dividers sharing one configuration bus and a
// common phase-restart strobe.
module divfreq_bank
    import divfreq_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = HALF_1HZ,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    output logic [NUM_CH-1:0] CLK_div,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] ch_we;

    // Indices at or above NUM_CH match no channel and are dropped.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            divfreq_ch #(
                .CNT_W        (CNT_W),
                .DEFAULT_HALF (DEFAULT_HALF)
            ) u_ch (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .we      (ch_we[gi]),
                .half_in (cfg_half),
                .en      (en[gi]),
                .sync    (sync),
                .clk_div (CLK_div[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule
